// File: rtl/mem_bus_pkg.sv
// Shared definitions for the multicore memory bus: arbiter FSM encoding,
// bus widths and the MMIO base addresses decoded by the slaves.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [ADDR_W-1:0] LED_BASE  = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] UART_BASE = 32'h2000_0000;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_grant+1, wrapping modulo N. The previous winner is checked last.
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] winner,
  output logic          any_req
);

  logic [GW-1:0] idx_s;

  // Scan from farthest to nearest so the nearest requester overwrites the rest
  always_comb begin
    winner  = {GW{1'b0}};
    idx_s   = {GW{1'b0}};
    any_req = |req;
    for (int i = N; i >= 1; i--) begin
      idx_s = GW'((int'(last_grant) + i) % N);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between NUM_MASTERS picorv32 cores.
// Define MEM_BUS_ARBITER_TIMEOUT_EN to build the slave-response watchdog (s_err).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GRANT_W     = $clog2(NUM_MASTERS),
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic [GRANT_W-1:0]            s_id,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          s_err
);

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]   pick_s;
  logic                 any_req_s;
  logic                 tmo_hit_s;
  logic                 done_s;

  logic [ADDR_W-1:0]    addr_arr_s  [NUM_MASTERS];
  logic [DATA_W-1:0]    wdata_arr_s [NUM_MASTERS];
  logic [STRB_W-1:0]    wstrb_arr_s [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr_s[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr_s[g] = m_wdata[g*DATA_W +: DATA_W];
    assign wstrb_arr_s[g] = m_wstrb[g*STRB_W +: STRB_W];
  end

  rr_priority_pick #(
    .N  (NUM_MASTERS),
    .GW (GRANT_W)
  ) u_pick (
    .req        (m_valid),
    .last_grant (last_grant_q),
    .winner     (pick_s),
    .any_req    (any_req_s)
  );

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog count: held at zero outside BUSY, so it starts from zero on entry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != BUSY) begin
      tmo_cnt_d = {CNT_W{1'b0}};
    end else if (!s_ready) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A real s_ready in the expiry cycle wins, so it is treated as a normal completion
  assign tmo_hit_s = (state_q == BUSY) && !s_ready && (tmo_cnt_q == CNT_W'(TIMEOUT));
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign done_s = (state_q == BUSY) && (s_ready || tmo_hit_s);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= {GRANT_W{1'b0}};
      last_grant_q <= GRANT_W'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: completion beats abort; an abort leaves the rotation untouched
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          grant_d = pick_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (!m_valid[grant_q]) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: slave-side fields always follow the granted master
  always_comb begin
    s_valid = 1'b0;
    m_ready = {NUM_MASTERS{1'b0}};
    m_rdata = s_rdata;
    s_err   = 1'b0;
    s_addr  = addr_arr_s[grant_q];
    s_wdata = wdata_arr_s[grant_q];
    s_wstrb = wstrb_arr_s[grant_q];
    s_id    = grant_q;
    case (state_q)
      BUSY: begin
        s_valid = m_valid[grant_q];
        if (done_s) begin
          m_ready[grant_q] = 1'b1;
        end else begin
          m_ready = {NUM_MASTERS{1'b0}};
        end
        if (tmo_hit_s) begin
          m_rdata = {DATA_W{1'b0}};
          s_err   = 1'b1;
        end else begin
          s_err   = 1'b0;
        end
      end
      IDLE: begin
        s_valid = 1'b0;
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with two masters.
// Timeout scenario is exercised when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [0:0]  s_id;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        s_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_MASTERS (N),
    .TIMEOUT     (16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_id    (s_id),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .s_err   (s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the arbitration cycle; runs one transaction granted to 'id'
  // with 'lat' wait cycles before s_ready, ending one step into the dead cycle.
  task automatic xact(input int id, input int lat, input logic [31:0] rdata, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = 2'b01 << id;
    #1;
    chk({tag, "_arb_svalid"}, 32'(s_valid), 32'd0);
    step();
    chk({tag, "_svalid"}, 32'(s_valid), 32'd1);
    chk({tag, "_sid"}, 32'(s_id), 32'(id));
    chk({tag, "_saddr"}, s_addr, m_addr[id*32 +: 32]);
    chk({tag, "_swdata"}, s_wdata, m_wdata[id*32 +: 32]);
    chk({tag, "_swstrb"}, 32'(s_wstrb), 32'(m_wstrb[id*4 +: 4]));
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_wait_mready"}, 32'(m_ready), 32'd0);
      step();
    end
    s_ready = 1'b1;
    s_rdata = rdata;
    #1;
    chk({tag, "_mready"}, 32'(m_ready), 32'(exp_rdy));
    chk({tag, "_mrdata"}, m_rdata, rdata);
    chk({tag, "_serr"}, 32'(s_err), 32'd0);
    step();
    s_ready = 1'b0;
    #1;
    chk({tag, "_dead_mready"}, 32'(m_ready), 32'd0);
    chk({tag, "_dead_svalid"}, 32'(s_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    m_valid = 2'b00;
    m_addr  = 64'd0;
    m_wdata = 64'd0;
    m_wstrb = 8'd0;
    s_ready = 1'b0;
    s_rdata = 32'd0;
    step();
    step();
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_serr", 32'(s_err), 32'd0);

    // s_ready while idle must not produce m_ready
    resetn  = 1'b1;
    s_ready = 1'b1;
    step();
    chk("idle_sready_mready", 32'(m_ready), 32'd0);
    chk("idle_sready_svalid", 32'(s_valid), 32'd0);
    s_ready = 1'b0;

    // Single master read, slave latency one cycle
    m_addr[31:0] = 32'h10;
    m_valid      = 2'b01;
    xact(0, 1, 32'hDEAD_BEEF, "single");
    m_valid = 2'b00;

    // Contention from reset: 0,1,0,1
    resetn = 1'b0;
    step();
    resetn  = 1'b1;
    m_addr  = {32'h0000_0200, 32'h0000_0100};
    m_wdata = {32'h0000_2222, 32'h0000_1111};
    m_valid = 2'b11;
    xact(0, 0, 32'hA000_0000, "cont0");
    xact(1, 0, 32'hA000_0001, "cont1");
    xact(0, 2, 32'hA000_0002, "cont2");
    xact(1, 0, 32'hA000_0003, "cont3");

    // Write from master1 alone
    m_valid        = 2'b10;
    m_addr[63:32]  = 32'h1000_0000;
    m_wdata[63:32] = 32'h0000_005A;
    m_wstrb[7:4]   = 4'b0001;
    xact(1, 0, 32'h0, "write");

    // Abort: master0 granted, drops valid before s_ready
    m_valid = 2'b11;
    #1;
    chk("abort_arb_svalid", 32'(s_valid), 32'd0);
    step();
    chk("abort_sid", 32'(s_id), 32'd0);
    chk("abort_svalid_hi", 32'(s_valid), 32'd1);
    m_valid = 2'b10;
    #1;
    chk("abort_svalid_fall", 32'(s_valid), 32'd0);
    chk("abort_mready", 32'(m_ready), 32'd0);
    step();
    chk("abort_idle_mready", 32'(m_ready), 32'd0);
    xact(1, 0, 32'hB000_0001, "after_abort");

    // Reset mid-transaction; first grant afterwards goes to master0
    m_valid = 2'b01;
    xact(0, 0, 32'hC000_0000, "pre_rst");
    #1;
    step();
    chk("midrst_busy_svalid", 32'(s_valid), 32'd1);
    step();
    step();
    resetn  = 1'b0;
    s_ready = 1'b1;
    step();
    chk("midrst_svalid", 32'(s_valid), 32'd0);
    chk("midrst_mready", 32'(m_ready), 32'd0);
    s_ready = 1'b0;
    resetn  = 1'b1;
    m_valid = 2'b11;
    xact(0, 0, 32'hC000_0001, "post_rst");
    m_valid = 2'b01;
    s_rdata = 32'hFFFF_FFFF;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Slave never answers: forced completion after 16 BUSY cycles
    #1;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_wait_mready", 32'(m_ready), 32'd0);
      chk("tmo_wait_serr", 32'(s_err), 32'd0);
      step();
    end
    chk("tmo_mready", 32'(m_ready), 32'd1);
    chk("tmo_mrdata", m_rdata, 32'd0);
    chk("tmo_serr", 32'(s_err), 32'd1);
    m_valid = 2'b00;
    step();
    chk("tmo_after_serr", 32'(s_err), 32'd0);
    chk("tmo_after_svalid", 32'(s_valid), 32'd0);
    chk("tmo_after_mready", 32'(m_ready), 32'd0);
`else
    // Without the watchdog BUSY waits indefinitely
    #1;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
    end
    chk("nowd_svalid", 32'(s_valid), 32'd1);
    chk("nowd_mready", 32'(m_ready), 32'd0);
    chk("nowd_serr", 32'(s_err), 32'd0);
    s_ready = 1'b1;
    #1;
    chk("nowd_done_mready", 32'(m_ready), 32'd1);
    chk("nowd_done_mrdata", m_rdata, 32'hFFFF_FFFF);
    step();
    s_ready = 1'b0;
    m_valid = 2'b00;
    #1;
    chk("nowd_after_mready", 32'(m_ready), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
